// File: rtl/adder_result_checker.sv
// adder_result_checker: queues expected adder results and scores returned results in order.
module adder_result_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     op_ready,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_sum,
  input  logic                     res_cout,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     err,
  output logic [WIDTH:0]           err_exp,
  output logic [WIDTH:0]           err_got,
  output logic                     unexpected
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop, match;
  logic [WIDTH:0] got;
  assign op_ready = pending != (PW+1)'(DEPTH);
  assign push = op_valid && op_ready;
  assign pop = res_valid && pending != '0;
  assign got = {res_cout, res_sum};
  assign match = mem[head] == got;
  always_ff @(posedge clk)
    if (push && !clear) mem[tail] <= {1'b0, op_a} + {1'b0, op_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      pending <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err <= 1'b0;
      err_exp <= '0;
      err_got <= '0;
      unexpected <= 1'b0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      pending <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err <= 1'b0;
      err_exp <= '0;
      err_got <= '0;
      unexpected <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      pending <= pending + (PW+1)'(push) - (PW+1)'(pop);
      if (pop && match && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      if (pop && !match && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      // only the first mismatch is captured
      if (pop && !match && !err) begin
        err <= 1'b1;
        err_exp <= mem[head];
        err_got <= got;
      end
      if (res_valid && !pop) unexpected <= 1'b1;
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: random and directed stimulus scored against a queue-based reference model.
module tb_adder_result_checker;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic op_valid = 1'b0, res_valid = 1'b0, res_cout = 1'b0, clear = 1'b0;
  logic [7:0] op_a = '0, op_b = '0, res_sum = '0;
  logic op_ready, err, unexpected, s_ready, s_err, s_unexp;
  logic [2:0] pending, s_pending;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0] s_pass, s_fail;
  logic [8:0] err_exp, err_got, s_exp, s_got;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] q[$];
  int m_pass, m_fail;
  bit m_err, m_unexp;
  logic [8:0] m_exp, m_got;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .clear(clear), .pending(pending),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .err_exp(err_exp), .err_got(err_got),
    .unexpected(unexpected));

  adder_result_checker #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(s_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .clear(clear), .pending(s_pending),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .err(s_err), .err_exp(s_exp), .err_got(s_got),
    .unexpected(s_unexp));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pass = 0;
    m_fail = 0;
    m_err = 0;
    m_unexp = 0;
    m_exp = '0;
    m_got = '0;
  endtask

  task automatic check_all();
    chk("pending", pending, q.size());
    chk("op_ready", op_ready, q.size() != DEPTH);
    chk("pass_cnt", pass_cnt, m_pass > 65535 ? 65535 : m_pass);
    chk("fail_cnt", fail_cnt, m_fail > 65535 ? 65535 : m_fail);
    chk("err", err, m_err);
    chk("err_exp", err_exp, m_exp);
    chk("err_got", err_got, m_got);
    chk("unexpected", unexpected, m_unexp);
    chk("sat_pass", s_pass, m_pass > 3 ? 3 : m_pass);
    chk("sat_fail", s_fail, m_fail > 3 ? 3 : m_fail);
    chk("sat_pending", s_pending, q.size());
  endtask

  task automatic step(input bit ov, input logic [7:0] a, input logic [7:0] b,
                      input bit rv, input logic [8:0] r, input bit clr);
    bit dpop, dpush;
    logic [8:0] e;
    op_valid = ov; op_a = a; op_b = b;
    res_valid = rv; {res_cout, res_sum} = r; clear = clr;
    if (clr) model_reset();
    else begin
      dpop = rv && q.size() != 0;
      dpush = ov && q.size() != DEPTH;
      if (dpop) begin
        e = q.pop_front();
        if (e == r) m_pass++;
        else begin
          m_fail++;
          if (!m_err) begin m_err = 1; m_exp = e; m_got = r; end
        end
      end else if (rv) m_unexp = 1;
      if (dpush) q.push_back(9'(a) + 9'(b));
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 8'h00, 8'h00, 0, 9'h000, 0);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single pass
    step(1, 8'h3C, 8'h15, 0, 9'h000, 0);
    idle();
    step(0, 8'h00, 8'h00, 1, 9'h051, 0);
    chk("single_pass", pass_cnt, 1);
    // carry mismatch then a second mismatch
    step(1, 8'hFF, 8'h01, 0, 9'h000, 0);
    step(0, 8'h00, 8'h00, 1, 9'h000, 0);
    step(1, 8'h10, 8'h10, 0, 9'h000, 0);
    step(0, 8'h00, 8'h00, 1, 9'h021, 0);
    chk("carry_exp", err_exp, 9'h100);
    chk("carry_got", err_got, 9'h000);
    chk("carry_fail", fail_cnt, 2);
    // full, backpressure and ordering
    step(1, 8'h00, 8'h00, 0, 9'h000, 1);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 8'(i), 0, 9'h000, 0);
    chk("full_ready", op_ready, 0);
    step(1, 8'h05, 8'h05, 0, 9'h000, 0);
    step(1, 8'h05, 8'h05, 1, 9'h002, 0);
    chk("pop_when_full", pending, 3);
    step(1, 8'h05, 8'h05, 0, 9'h000, 0);
    for (int i = 2; i <= 5; i++) step(0, 8'h00, 8'h00, 1, 9'(2 * i), 0);
    chk("order_pass", pass_cnt, 5);
    chk("sat_pass3", s_pass, 3);
    // empty result alongside a push
    step(0, 8'h00, 8'h00, 0, 9'h000, 1);
    step(1, 8'h00, 8'h00, 1, 9'h000, 0);
    chk("unexp_set", unexpected, 1);
    chk("unexp_pend", pending, 1);
    step(0, 8'h00, 8'h00, 1, 9'h000, 0);
    chk("unexp_pass", pass_cnt, 1);
    // mid-operation reset and clear
    step(1, 8'h01, 8'h02, 0, 9'h000, 0);
    step(1, 8'h03, 8'h04, 1, 9'h1FF, 0);
    rst_pulse();
    chk("rst_ready", op_ready, 1);
    step(1, 8'h01, 8'h02, 0, 9'h000, 0);
    step(1, 8'h01, 8'h02, 1, 9'h1FF, 0);
    step(1, 8'h07, 8'h07, 0, 9'h000, 1);
    chk("clr_pend", pending, 0);
    step(0, 8'h00, 8'h00, 1, 9'h003, 0);
    chk("clr_unexp", unexpected, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] r;
      r = (q.size() != 0 && $urandom_range(3) != 0) ? q[0] : 9'($urandom);
      if ($urandom_range(199) == 0) rst_pulse();
      step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), r, $urandom_range(63) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
